tx_fifo_buffer: RTL and testbench

Transmit-side byte FIFO of the packet path. It holds bytes pushed by the packetizer until the serializer drains them. Storage is indexed by a tail (write) pointer and a head (read) pointer. Each pointer wraps at DEPTH-1 and carries a wrap-toggle bit, which lets the block tell full from empty without a spare slot. It provides first-word-fall-through read data, full/empty/count status and sticky error flags.

---
 rtl/tx_fifo_buffer.sv | 106 ++++++++++
 tb/tb_tx_fifo_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_fifo_buffer.sv
// rtl/tx_fifo_buffer.sv - transmit-side byte FIFO with FWFT read data, status and sticky error flags
module tx_fifo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 6,
  parameter int PTR_BITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  tx_enq,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_deq,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_BITS:0]     count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam logic [PTR_BITS-1:0] PTR_LAST = PTR_BITS'(DEPTH - 1);
  localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);
  localparam logic [PTR_BITS:0]   CNT_ONE  = (PTR_BITS + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_BITS-1:0]   tail_ptr;
  logic [PTR_BITS-1:0]   head_ptr;
  logic                  tail_tog;
  logic                  head_tog;
  logic [PTR_BITS:0]     count_q;
  logic                  acc_enq;
  logic                  acc_deq;
  logic                  tail_wrap;
  logic                  head_wrap;
  logic                  ovf_set;
  logic                  udf_set;

  // Status, acceptance and error-set terms; the toggle bits separate full from empty when pointers meet
  always_comb begin
    empty     = (head_ptr == tail_ptr) && (head_tog == tail_tog);
    full      = (head_ptr == tail_ptr) && (head_tog != tail_tog);
    acc_deq   = tx_deq && !empty;
    acc_enq   = tx_enq && (!full || acc_deq);
    tail_wrap = (tail_ptr == PTR_LAST);
    head_wrap = (head_ptr == PTR_LAST);
    ovf_set   = tx_enq && full && !acc_deq;
    udf_set   = tx_deq && empty;
    count     = count_q;
    rd_data   = empty ? '0 : mem[head_ptr];
  end

  // Pointer, toggle and occupancy registers; flush wins over any push or pop in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_ptr <= '0;
      tail_tog <= 1'b0;
      head_ptr <= '0;
      head_tog <= 1'b0;
      count_q  <= '0;
    end else if (flush) begin
      tail_ptr <= '0;
      tail_tog <= 1'b0;
      head_ptr <= '0;
      head_tog <= 1'b0;
      count_q  <= '0;
    end else begin
      if (acc_enq) begin
        tail_ptr <= tail_wrap ? '0 : tail_ptr + PTR_ONE;
        tail_tog <= tail_tog ^ tail_wrap;
      end
      if (acc_deq) begin
        head_ptr <= head_wrap ? '0 : head_ptr + PTR_ONE;
        head_tog <= head_tog ^ head_wrap;
      end
      if (acc_enq && !acc_deq) begin
        count_q <= count_q + CNT_ONE;
      end else if (acc_deq && !acc_enq) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  // Entry storage; popped entries are left in place and flush does not touch contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (acc_enq && !flush) begin
      mem[tail_ptr] <= tx_data;
    end
  end

  // Sticky error flags; a new violation in the err_clr cycle keeps its flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow && !err_clr) || ovf_set;
      underflow <= (underflow && !err_clr) || udf_set;
    end
  end

endmodule

// File: tb/tb_tx_fifo_buffer.sv
// tb/tb_tx_fifo_buffer.sv - self-checking bench for tx_fifo_buffer against a queue model
module tb_tx_fifo_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 6;
  localparam int PB    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          tx_enq = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_deq = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [PB:0]   count;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  tx_fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_BITS(PB)) dut (
    .clk(clk), .rst(rst), .flush(flush), .tx_enq(tx_enq), .tx_data(tx_data),
    .tx_deq(tx_deq), .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_rd();
    return (q.size() != 0) ? q[0] : '0;
  endfunction

  // One clock cycle of stimulus; the model advances from the pre-edge occupancy
  task automatic drive(input logic enq, input logic [DW-1:0] d, input logic deq,
                       input logic fl, input logic ec);
    logic m_full, m_empty, pop_ok, push_ok;
    @(negedge clk);
    tx_enq = enq; tx_data = d; tx_deq = deq; flush = fl; err_clr = ec;
    @(posedge clk);
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    pop_ok  = deq && !m_empty;
    push_ok = enq && (!m_full || pop_ok);
    m_ovf = (m_ovf && !ec) || (enq && m_full && !pop_ok);
    m_udf = (m_udf && !ec) || (deq && m_empty);
    if (fl) begin
      q.delete();
    end else begin
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(d);
    end
    #1;
    tx_enq = 1'b0; tx_deq = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {overflow, underflow}); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b0);
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got %b exp 0", i, empty); end
      checks++; if (count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
      checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL fill_rd_data[%0d] got %h exp 11", i, rd_data); end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
    checks++; if (dut.tail_ptr !== 3'd0) begin errors++; $display("FAIL fill_tail_ptr got %0d exp 0", dut.tail_ptr); end
    checks++; if (dut.tail_tog !== 1'b1) begin errors++; $display("FAIL fill_tail_tog got %b exp 1", dut.tail_tog); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (rd_data !== 8'h11 + 8'(i)) begin errors++; $display("FAIL drain_rd_data[%0d] got %h exp %h", i, rd_data, 8'h11 + 8'(i)); end
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL drain_rd_last got %h exp 00", rd_data); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count); end
    checks++; if (dut.head_tog !== 1'b1) begin errors++; $display("FAIL drain_head_tog got %b exp 1", dut.head_tog); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL drain_underflow got %b exp 0", underflow); end
  endtask

  task automatic test_errors();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL ovf_count got %0d exp 6", count); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (rd_data !== exp_rd()) begin errors++; $display("FAIL ovf_contents[%0d] got %h exp %h", i, rd_data, exp_rd()); end
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_flag got %b exp 1", underflow); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL udf_count got %0d exp 0", count); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL errclr_flags got %b exp 00", {overflow, underflow}); end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL errclr_set_wins got %b exp 1", underflow); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL simfull_count got %0d exp 6", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simfull_overflow got %b exp 0", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (rd_data !== exp_rd()) begin errors++; $display("FAIL simfull_order[%0d] got %h exp %h", i, rd_data, exp_rd()); end
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    drive(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL simempty_count got %0d exp 1", count); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL simempty_underflow got %b exp 1", underflow); end
    checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL simempty_rd_data got %h exp 3c", rd_data); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    logic prev_ovf;
    while (q.size() < 3) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    prev_ovf = m_ovf;
    drive(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b exp 1", empty); end
    checks++; if (overflow !== prev_ovf) begin errors++; $display("FAIL flush_overflow got %b exp %b", overflow, prev_ovf); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL flush_rd_data got %h exp 00", rd_data); end
  endtask

  task automatic test_async_reset();
    while (q.size() < 4) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL arst_pre_count got %0d exp 4", count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL arst_count got %0d exp 0", count); end
    checks++; if ({empty, full} !== 2'b10) begin errors++; $display("FAIL arst_status got %b exp 10", {empty, full}); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL arst_rd_data got %h exp 00", rd_data); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL arst_flags got %b exp 00", {overflow, underflow}); end
    @(negedge clk);
    rst = 1'b0;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (rd_data !== 8'h00 || count !== 4'd0) begin errors++; $display("FAIL arst_post got rd %h cnt %0d exp 00/0", rd_data, count); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic e, d, f, c;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(99) < 60);
      d = ($urandom_range(99) < 50);
      f = ($urandom_range(99) < 3);
      c = ($urandom_range(99) < 5);
      drive(e, 8'($urandom), d, f, c);
      checks++;
      if (rd_data !== exp_rd() || count !== 4'(q.size()) || empty !== (q.size() == 0) ||
          full !== (q.size() == DEPTH) || overflow !== m_ovf || underflow !== m_udf) begin
        errors++;
        $display("FAIL random[%0d] got rd %h cnt %0d e %b f %b o %b u %b exp rd %h cnt %0d o %b u %b",
                 i, rd_data, count, empty, full, overflow, underflow, exp_rd(), q.size(), m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_errors();
    test_simultaneous();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
